// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sweep controller: wave codes, FSM encoding,
// default widths and wave-code helpers.
package awg_pkg;

  localparam int FREQ_W_DEF  = 14;
  localparam int DWELL_W_DEF = 24;

  localparam logic [4:0] WAVE_SAW  = 5'd0;
  localparam logic [4:0] WAVE_TRI  = 5'd1;
  localparam logic [4:0] WAVE_SQR  = 5'd2;
  localparam logic [4:0] WAVE_SIN  = 5'd3;
  localparam logic [4:0] WAVE_MUTE = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // Codes the generator does not understand are silenced.
  function automatic logic [4:0] wave_sel(input logic [4:0] code, input logic [4:0] mute);
    if (code <= WAVE_SIN) begin
      return code;
    end else begin
      return mute;
    end
  endfunction

  function automatic logic [4:0] wave_next(input logic [4:0] code);
    case (code)
      WAVE_SAW: return WAVE_TRI;
      WAVE_TRI: return WAVE_SQR;
      WAVE_SQR: return WAVE_SIN;
      WAVE_SIN: return WAVE_SAW;
      default:  return code;
    endcase
  endfunction

endpackage

// File: rtl/awg_dwell_timer.sv
// Per-point dwell counter: counts while run is high and flags the last cycle
// of a point; a programmed dwell of zero behaves as one.
module awg_dwell_timer
  import awg_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] last_s;

  always_comb begin
    if (dwell == '0) begin
      last_s = '0;
    end else begin
      last_s = dwell - ONE;
    end
    expire = run && (cnt_q == last_s);
    if (run && !expire) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Linear frequency sweep sequencer driving the waveform generator controls.
// Optional build macro AWG_SWEEP_AUTOWAVE_EN: rotate the wave and repeat instead of finishing.
module awg_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int         FREQ_W    = FREQ_W_DEF,
  parameter int         DWELL_W   = DWELL_W_DEF,
  parameter logic [4:0] MUTE_CODE = WAVE_MUTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [4:0]         cfg_wave,
  input  logic [FREQ_W-1:0]  cfg_f_start,
  input  logic [FREQ_W-1:0]  cfg_f_stop,
  input  logic [FREQ_W-1:0]  cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [7:0]         cfg_amp,
  input  logic [7:0]         cfg_phase,
  output logic [4:0]         state,
  output logic [FREQ_W-1:0]  state_freq,
  output logic [7:0]         state_amp,
  output logic [7:0]         state_phase,
  output logic               busy,
  output logic               done,
  output logic               sweep_tick
);

  sweep_state_e       fsm_q, fsm_d;
  logic [4:0]         wave_q, wave_d, wsh_q, wsh_d;
  logic [FREQ_W-1:0]  freq_q, freq_d, fstart_q, fstart_d, fstop_q, fstop_d, fstep_q, fstep_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         amp_q, amp_d, phase_q, phase_d, ash_q, ash_d, psh_q, psh_d;
  logic               busy_q, busy_d, done_q, done_d, tick_q, tick_d;
  logic               capture_s, rotate_s, run_s, expire_s, last_s;
  logic [FREQ_W:0]    sum_s;

  assign run_s = (fsm_q == ST_DWELL);

  awg_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run_s),
    .dwell  (dwell_q),
    .expire (expire_s)
  );

  // The extra sum bit keeps a carry-out from wrapping below f_stop.
  always_comb begin
    sum_s  = {1'b0, freq_q} + {1'b0, fstep_q};
    last_s = (freq_q == fstop_q) || (fstep_q == '0) || (fstart_q > fstop_q);
    fsm_d = fsm_q;     wave_d = wave_q;   freq_d = freq_q;
    amp_d = amp_q;     phase_d = phase_q;
    busy_d = busy_q;   done_d = done_q;   tick_d = 1'b0;
    capture_s = 1'b0;  rotate_s = 1'b0;
    if (stop) begin
      fsm_d = ST_IDLE;  wave_d = MUTE_CODE; freq_d = '0;
      amp_d = 8'd0;     phase_d = 8'd0;
      busy_d = 1'b0;    done_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            capture_s = 1'b1;
            fsm_d  = ST_LOAD;
            busy_d = 1'b1;
            done_d = 1'b0;
          end else begin
            fsm_d = fsm_q;
          end
        end
        ST_LOAD: begin
          wave_d  = wave_sel(wsh_q, MUTE_CODE);
          freq_d  = fstart_q;
          amp_d   = ash_q;
          phase_d = psh_q;
          tick_d  = 1'b1;
          fsm_d   = ST_DWELL;
        end
        ST_DWELL: begin
          if (expire_s) begin
            if (last_s) begin
`ifdef AWG_SWEEP_AUTOWAVE_EN
              rotate_s = 1'b1;
              fsm_d    = ST_LOAD;
`else
              fsm_d  = ST_DONE;
              busy_d = 1'b0;
              done_d = 1'b1;
`endif
            end else if (sum_s > {1'b0, fstop_q}) begin
              freq_d = fstop_q;
              tick_d = 1'b1;
            end else begin
              freq_d = sum_s[FREQ_W-1:0];
              tick_d = 1'b1;
            end
          end else begin
            fsm_d = ST_DWELL;
          end
        end
        default: begin
          fsm_d  = ST_IDLE;  wave_d = MUTE_CODE; freq_d = '0;
          amp_d  = 8'd0;     phase_d = 8'd0;
          busy_d = 1'b0;     done_d = 1'b0;
        end
      endcase
    end
  end

  // Shadow config only changes on an accepted start (or a wave rotation).
  always_comb begin
    wsh_d = wsh_q;  fstart_d = fstart_q;  fstop_d = fstop_q;  fstep_d = fstep_q;
    dwell_d = dwell_q;  ash_d = ash_q;  psh_d = psh_q;
    if (capture_s) begin
      wsh_d = cfg_wave;     fstart_d = cfg_f_start;  fstop_d = cfg_f_stop;
      fstep_d = cfg_f_step; dwell_d = cfg_dwell;     ash_d = cfg_amp;
      psh_d = cfg_phase;
    end else if (rotate_s) begin
      wsh_d = wave_next(wsh_q);
    end else begin
      wsh_d = wsh_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;  wave_q <= MUTE_CODE;  freq_q <= '0;
      amp_q <= 8'd0;     phase_q <= 8'd0;
      busy_q <= 1'b0;    done_q <= 1'b0;       tick_q <= 1'b0;
      wsh_q <= 5'd0;     fstart_q <= '0;       fstop_q <= '0;   fstep_q <= '0;
      dwell_q <= '0;     ash_q <= 8'd0;        psh_q <= 8'd0;
    end else begin
      fsm_q <= fsm_d;    wave_q <= wave_d;     freq_q <= freq_d;
      amp_q <= amp_d;    phase_q <= phase_d;
      busy_q <= busy_d;  done_q <= done_d;     tick_q <= tick_d;
      wsh_q <= wsh_d;    fstart_q <= fstart_d; fstop_q <= fstop_d; fstep_q <= fstep_d;
      dwell_q <= dwell_d; ash_q <= ash_d;      psh_q <= psh_d;
    end
  end

  assign state       = wave_q;
  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sweep_tick  = tick_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Scoreboard bench for awg_sweep_ctrl: directed sweeps push expected ticks and
// done events; a monitor pops them as the DUT presents sweep_tick / done.
module tb_awg_sweep_ctrl;

  localparam int FW = 14;
  localparam int DW = 24;
  localparam int EV_TICK = 0;
  localparam int EV_DONE = 1;

  typedef struct {
    int kind;
    int edge_n;
    int wave;
    int freq;
    int amp;
    int ph;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [4:0]    cfg_wave = 5'd0;
  logic [FW-1:0] cfg_f_start = '0;
  logic [FW-1:0] cfg_f_stop = '0;
  logic [FW-1:0] cfg_f_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [7:0]    cfg_amp = 8'd0;
  logic [7:0]    cfg_phase = 8'd0;
  logic [4:0]    state;
  logic [FW-1:0] state_freq;
  logic [7:0]    state_amp;
  logic [7:0]    state_phase;
  logic          busy;
  logic          done;
  logic          sweep_tick;

  awg_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_wave(cfg_wave), .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop),
    .cfg_f_step(cfg_f_step), .cfg_dwell(cfg_dwell), .cfg_amp(cfg_amp),
    .cfg_phase(cfg_phase), .state(state), .state_freq(state_freq),
    .state_amp(state_amp), .state_phase(state_phase), .busy(busy),
    .done(done), .sweep_tick(sweep_tick)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edges);
    end
  endtask

  task automatic push_ev(input int kind, input int edge_n, input int wave,
                         input int freq, input int amp, input int ph);
    ev_t e;
    e.kind = kind; e.edge_n = edge_n; e.wave = wave;
    e.freq = freq; e.amp = amp; e.ph = ph;
    exp_q.push_back(e);
  endtask

  // Start a sweep and queue its hand-computed points: point i at edge k+1+i*d.
  task automatic run_sweep(input int wave, input int fs, input int fe, input int st,
                           input int dw, input int amp, input int ph, input int xw,
                           input int d, input int n, input int p0, input int p1,
                           input int p2, input int p3, input int dn);
    int pts[4];
    int k;
    pts[0] = p0; pts[1] = p1; pts[2] = p2; pts[3] = p3;
    cfg_wave = 5'(wave); cfg_f_start = FW'(fs); cfg_f_stop = FW'(fe);
    cfg_f_step = FW'(st); cfg_dwell = DW'(dw); cfg_amp = 8'(amp); cfg_phase = 8'(ph);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = edges;
    for (int i = 0; i < n; i++) push_ev(EV_TICK, k + 1 + i * d, xw, pts[i], amp, ph);
    if (dn != 0) push_ev(EV_DONE, k + 1 + n * d, xw, pts[n-1], amp, ph);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events still pending at edge %0d", exp_q.size(), edges);
      exp_q.delete();
    end
  endtask

  task automatic stop_and_check(input string tag);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk({tag, "_state"}, int'(state), 10);
    chk({tag, "_freq"}, int'(state_freq), 0);
    chk({tag, "_amp"}, int'(state_amp), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: pops and compares on every tick / done rise; checks hold in between.
  initial begin
    ev_t  e;
    logic done_prev;
    int   hold_freq;
    bit   hold_ok;
    done_prev = 1'b0; hold_freq = 0; hold_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_ok = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (sweep_tick) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_tick: got freq %0d at edge %0d, expected no tick", state_freq, edges);
          end else begin
            e = exp_q.pop_front();
            chk("tick_kind", e.kind, EV_TICK);
            chk("tick_edge", edges, e.edge_n);
            chk("tick_state", int'(state), e.wave);
            chk("tick_freq", int'(state_freq), e.freq);
            chk("tick_amp", int'(state_amp), e.amp);
            chk("tick_phase", int'(state_phase), e.ph);
            hold_freq = e.freq;
            hold_ok = 1'b1;
          end
        end else if (hold_ok && (busy || done)) begin
          chk("hold_freq", int'(state_freq), hold_freq);
        end
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done=1 at edge %0d, expected 0", edges);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", e.kind, EV_DONE);
            chk("done_edge", edges, e.edge_n);
            chk("done_busy", int'(busy), 0);
            chk("done_freq", int'(state_freq), e.freq);
          end
        end
        if (!busy && !done) hold_ok = 1'b0;
        done_prev = done;
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_state", int'(state), 10);
    chk("rst_freq", int'(state_freq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(sweep_tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef AWG_SWEEP_AUTOWAVE_EN
    // Rotation: each round is 4 points of 4 cycles plus one LOAD cycle.
    begin
      int k0;
      run_sweep(0, 100, 130, 10, 4, 8'h40, 8'h11, 0, 4, 4, 100, 110, 120, 130, 0);
      k0 = edges;
      for (int r = 1; r < 5; r++)
        for (int i = 0; i < 4; i++)
          push_ev(EV_TICK, k0 + 1 + 17 * r + 4 * i, r % 4, 100 + 10 * i, 8'h40, 8'h11);
      wait_drain(200);
      stop_and_check("auto_stop");
    end
`else
    // Basic sweep, then restart from DONE with a clamped stop.
    run_sweep(3, 100, 130, 10, 4, 8'h40, 8'h11, 3, 4, 4, 100, 110, 120, 130, 1);
    wait_drain(100);
    chk("basic_done_level", int'(done), 1);
    run_sweep(2, 100, 125, 10, 4, 8'h22, 8'h33, 2, 4, 4, 100, 110, 120, 125, 1);
    wait_drain(100);
    stop_and_check("clamp_stop");
    // Carry-out past the 14-bit range clamps to f_stop.
    run_sweep(1, 16380, 16383, 10, 3, 8'h7F, 8'h01, 1, 3, 2, 16380, 16383, 0, 0, 1);
    wait_drain(100);
    stop_and_check("ovf_stop");
    run_sweep(0, 100, 130, 10, 0, 8'h05, 8'h06, 0, 1, 4, 100, 110, 120, 130, 1);
    wait_drain(100);
    stop_and_check("dw0_stop");
    run_sweep(3, 500, 900, 0, 3, 8'h10, 8'h20, 3, 3, 1, 500, 0, 0, 0, 1);
    wait_drain(100);
    stop_and_check("step0_stop");
    run_sweep(3, 200, 100, 10, 2, 8'h30, 8'h40, 3, 2, 1, 200, 0, 0, 0, 1);
    wait_drain(100);
    stop_and_check("rev_stop");
    run_sweep(7, 100, 130, 30, 2, 8'hA5, 8'h5A, 10, 2, 2, 100, 130, 0, 0, 1);
    wait_drain(100);
    stop_and_check("badwave_stop");

    // Stop mid-DWELL: only the first point appears.
    run_sweep(3, 100, 130, 10, 4, 8'h40, 8'h11, 3, 4, 1, 100, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    stop_and_check("abort");
    wait_drain(20);

    // start and stop together from IDLE: stays idle.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_state", int'(state), 10);
    repeat (4) @(negedge clk);
    chk("startstop_busy_later", int'(busy), 0);

    // Mid-sweep start and cfg changes are ignored.
    run_sweep(3, 100, 130, 10, 4, 8'h40, 8'h11, 3, 4, 4, 100, 110, 120, 130, 1);
    repeat (2) @(negedge clk);
    cfg_wave = 5'd1; cfg_f_start = 14'd999; cfg_f_step = 14'd1;
    cfg_dwell = 24'd2; cfg_amp = 8'd0; cfg_phase = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(100);
    stop_and_check("ignore_stop");

    // Async reset between edges, then a fresh sweep.
    run_sweep(3, 100, 130, 10, 4, 8'h40, 8'h11, 3, 4, 1, 100, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(state), 10);
    chk("arst_freq", int'(state_freq), 0);
    chk("arst_amp", int'(state_amp), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(5);
    run_sweep(3, 100, 130, 10, 4, 8'h40, 8'h11, 3, 4, 4, 100, 110, 120, 130, 1);
    wait_drain(100);
    stop_and_check("arst_final_stop");
`endif

    repeat (5) @(negedge clk);
    wait_drain(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
